// File: rtl/oflow_pkg.sv
// Shared types and default sizes for the registration bank.
//   OFLOW_DATA_W / OFLOW_DEPTH : default record width and entries per bank
//   scan_state_t               : scan engine states
//   oflow_rec_t                : one registration record at default width
package oflow_pkg;
  localparam int OFLOW_DATA_W = 112;
  localparam int OFLOW_DEPTH  = 256;

  typedef enum logic [1:0] {IDLE, SEEK, FETCH, PRESENT} scan_state_t;

  typedef logic [OFLOW_DATA_W-1:0] oflow_rec_t;
endpackage

// File: rtl/oflow_registration_bank_if.sv
// Bundle of the registration bank's control, write, random-read and scan
// stream signals.
//   slave  : the bank itself (write/read/scan requests in, data out)
//   master : the surrounding PE logic driving it
interface oflow_registration_bank_if
  import oflow_pkg::*;
#(
  parameter int DATA_W = OFLOW_DATA_W,
  parameter int ADDR_W = $clog2(OFLOW_DEPTH)
) ();
  logic              EN;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              frame_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_miss;
  logic              scan_start;
  logic [DATA_W-1:0] scan_data;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_valid;
  logic              scan_ready;
  logic              scan_last;
  logic              scan_busy;
  logic [ADDR_W:0]   cur_count;
  logic [ADDR_W:0]   prev_count;

  modport slave (
    input  EN, wr, addr, data_in, frame_done, rd_req, rd_addr, scan_start, scan_ready,
    output rd_data, rd_valid, rd_miss, scan_data, scan_addr, scan_valid, scan_last,
           scan_busy, cur_count, prev_count
  );

  modport master (
    output EN, wr, addr, data_in, frame_done, rd_req, rd_addr, scan_start, scan_ready,
    input  rd_data, rd_valid, rd_miss, scan_data, scan_addr, scan_valid, scan_last,
           scan_busy, cur_count, prev_count
  );
endinterface

// File: rtl/oflow_reg_bank.sv
// One bank of registration records: DEPTH x DATA_W storage, per-entry valid
// bits and an occupancy counter.
//   clk, rst_b        : clock, async active-low reset (valid bits and count only)
//   we/waddr/wdata    : write port; sets the entry's valid bit
//   clr               : clears all valid bits and the count in one edge
//   raddr_a/_b        : two independent combinational read ports
//   rdata_*/rvalid_*  : record and valid bit at the read address
//   count             : number of valid entries
module oflow_reg_bank
  import oflow_pkg::*;
#(
  parameter int DATA_W = OFLOW_DATA_W,
  parameter int DEPTH  = OFLOW_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic [ADDR_W:0]   count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              w_in, a_in, b_in;

  // Range checks only matter when DEPTH is not a power of two.
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign w_in = 1'b1;
    assign a_in = 1'b1;
    assign b_in = 1'b1;
  end else begin : g_part
    assign w_in = int'(waddr) < DEPTH;
    assign a_in = int'(raddr_a) < DEPTH;
    assign b_in = int'(raddr_b) < DEPTH;
  end

  assign rdata_a  = mem[raddr_a];
  assign rvalid_a = a_in && valid[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign rvalid_b = b_in && valid[raddr_b];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
      count <= '0;
    end else if (clr) begin
      valid <= '0;
      count <= '0;
    end else if (we && w_in) begin
      valid[waddr] <= 1'b1;
      if (!valid[waddr]) count <= count + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we && w_in) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/oflow_registration_bank.sv
// Ping-pong registration store: current bank takes writes, previous bank is
// served to a random-read port and a handshaked scan stream.
//   clk, reset_N : clock, async active-low reset
//   bus (slave)  : enable, write, frame_done swap request, random read,
//                  scan start/stream handshake, occupancy counts
//
// state   | meaning
// IDLE    | no scan; bank swaps allowed
// SEEK    | stepping idx looking for the next valid previous-bank entry
// FETCH   | capturing record and index of the found entry
// PRESENT | scan_valid high, holding the beat until scan_ready
module oflow_registration_bank
  import oflow_pkg::*;
#(
  parameter  int DATA_W = OFLOW_DATA_W,
  parameter  int DEPTH  = OFLOW_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic                      clk,
  input logic                      reset_N,
  oflow_registration_bank_if.slave bus
);
  scan_state_t       state;
  logic              cur_bank, prev_bank, swap_pending, do_swap;
  logic [ADDR_W-1:0] idx, scan_addr_q;
  logic [ADDR_W:0]   remaining, prev_count;
  logic [DATA_W-1:0] scan_data_q, rd_data_q;
  logic              scan_valid_q, scan_last_q, scan_busy_q, rd_valid_q, rd_miss_q;
  logic [DATA_W-1:0] rdata_a [2];
  logic [DATA_W-1:0] rdata_b [2];
  logic [ADDR_W:0]   count [2];
  logic [1:0]        rvalid_a, rvalid_b, we, clr;

  assign prev_bank = ~cur_bank;
  // A swap only happens with the scan engine idle, so the previous bank never
  // changes under a running scan; a deferred request fires once IDLE is reached.
  assign do_swap   = bus.EN && (state == IDLE) && (bus.frame_done || swap_pending);

  assign we[0]  = bus.EN && bus.wr && !cur_bank;
  assign we[1]  = bus.EN && bus.wr && cur_bank;
  // The bank being cleared is the one about to become current.
  assign clr[0] = do_swap && cur_bank;
  assign clr[1] = do_swap && !cur_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    oflow_reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk      (clk),
      .rst_b    (reset_N),
      .we       (we[b]),
      .waddr    (bus.addr),
      .wdata    (bus.data_in),
      .clr      (clr[b]),
      .raddr_a  (bus.rd_addr),
      .rdata_a  (rdata_a[b]),
      .rvalid_a (rvalid_a[b]),
      .raddr_b  (idx),
      .rdata_b  (rdata_b[b]),
      .rvalid_b (rvalid_b[b]),
      .count    (count[b])
    );
  end

  assign prev_count     = count[prev_bank];
  assign bus.cur_count  = count[cur_bank];
  assign bus.prev_count = prev_count;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_miss    = rd_miss_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_addr  = scan_addr_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_last  = scan_last_q;
  assign bus.scan_busy  = scan_busy_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
    end else if (bus.EN) begin
      rd_valid_q <= bus.rd_req && rvalid_a[prev_bank];
      rd_miss_q  <= bus.rd_req && !rvalid_a[prev_bank];
      if (bus.rd_req) rd_data_q <= rvalid_a[prev_bank] ? rdata_a[prev_bank] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state        <= IDLE;
      idx          <= '0;
      remaining    <= '0;
      scan_data_q  <= '0;
      scan_addr_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_last_q  <= 1'b0;
      scan_busy_q  <= 1'b0;
      cur_bank     <= 1'b0;
      swap_pending <= 1'b0;
    end else if (bus.EN) begin
      if (do_swap) begin
        cur_bank     <= ~cur_bank;
        swap_pending <= 1'b0;
      end else if (bus.frame_done) begin
        swap_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // A scan requested in the same cycle as a swap would read a bank
          // that is changing under it, so the start is dropped.
          if (bus.scan_start && !do_swap && prev_count != '0) begin
            state       <= SEEK;
            idx         <= '0;
            remaining   <= prev_count;
            scan_busy_q <= 1'b1;
          end
        end
        SEEK: begin
          if (rvalid_b[prev_bank]) begin
            state <= FETCH;
          end else if (idx == ADDR_W'(DEPTH-1)) begin
            state       <= IDLE;
            scan_busy_q <= 1'b0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        FETCH: begin
          scan_data_q  <= rdata_b[prev_bank];
          scan_addr_q  <= idx;
          scan_valid_q <= 1'b1;
          scan_last_q  <= remaining == (ADDR_W+1)'(1);
          state        <= PRESENT;
        end
        PRESENT: begin
          if (bus.scan_ready) begin
            remaining    <= remaining - (ADDR_W+1)'(1);
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
            if (scan_last_q) begin
              state       <= IDLE;
              scan_busy_q <= 1'b0;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= SEEK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oflow_registration_bank.sv
module tb_oflow_registration_bank;
  import oflow_pkg::*;
  localparam int ADDR_W = $clog2(OFLOW_DEPTH);

  logic clk = 1'b0;
  logic reset_N;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  oflow_registration_bank_if #(.DATA_W(OFLOW_DATA_W), .ADDR_W(ADDR_W)) bus ();

  oflow_registration_bank #(.DATA_W(OFLOW_DATA_W), .DEPTH(OFLOW_DEPTH)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  logic [ADDR_W-1:0] beat_addr [8];
  oflow_rec_t        beat_data [8];
  logic              beat_last [8];
  int                n_beats, last_beat_cyc, end_cyc;

  function automatic oflow_rec_t mk(input logic [7:0] a, input logic [7:0] s);
    return {14{a ^ s}};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_one(input logic [ADDR_W-1:0] a, input oflow_rec_t d, input bit fd);
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = a; bus.data_in = d; bus.frame_done = fd;
    @(negedge clk);
    bus.wr = 1'b0; bus.frame_done = 1'b0;
  endtask

  task automatic pulse_fd();
    @(negedge clk);
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    bus.rd_req = 1'b0;
  endtask

  // Cycle k of the loop is observed at the negedge following start edge k.
  task automatic do_scan(input bit toggle, input bit inject);
    bit                held;
    logic [ADDR_W-1:0] h_addr;
    oflow_rec_t        h_data;
    n_beats = 0; held = 0; end_cyc = -1; last_beat_cyc = -1;
    @(negedge clk);
    bus.scan_start = 1'b1;
    bus.scan_ready = !toggle;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      bus.scan_start = 1'b0;
      if (toggle) bus.scan_ready = ((cyc / 2) % 2) == 1;
      if (inject) begin
        bus.frame_done = (cyc == 2) || (cyc == 5);
        bus.wr         = (cyc == 3) || (cyc == 4);
        bus.addr       = (cyc == 3) ? ADDR_W'(5) : ADDR_W'(6);
        bus.data_in    = (cyc == 3) ? mk(5, 3) : mk(6, 3);
        if (cyc == 100) check_eq("prev_count_during_scan", bus.prev_count, 3);
      end
      if (!bus.scan_busy) begin
        end_cyc = cyc;
        break;
      end
      if (bus.scan_valid) begin
        if (held) begin
          check_eq("hold_addr", bus.scan_addr, h_addr);
          check_eq("hold_data", bus.scan_data, h_data);
        end
        if (bus.scan_ready) begin
          if (n_beats < 8) begin
            beat_addr[n_beats] = bus.scan_addr;
            beat_data[n_beats] = bus.scan_data;
            beat_last[n_beats] = bus.scan_last;
          end
          if (bus.scan_last) last_beat_cyc = cyc;
          n_beats++;
          held = 0;
        end else begin
          held = 1; h_addr = bus.scan_addr; h_data = bus.scan_data;
        end
      end
    end
    bus.wr = 1'b0; bus.frame_done = 1'b0;
    if (end_cyc < 0) check_eq("scan_timeout", 0, 1);
  endtask

  task automatic check_abc_beats();
    logic [ADDR_W-1:0] ea [3];
    ea[0] = 3; ea[1] = 7; ea[2] = 200;
    check_eq("beat_count", n_beats, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("beat_addr", beat_addr[i], ea[i]);
      check_eq("beat_data", beat_data[i], mk(ea[i], 0));
      check_eq("beat_last", beat_last[i], i == 2);
    end
    check_eq("busy_fall_after_last", end_cyc, last_beat_cyc + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.EN = 1'b1; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
    bus.frame_done = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.scan_start = 1'b0; bus.scan_ready = 1'b0;
    reset_N = 1'b1;
    #2 reset_N = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cur_count", bus.cur_count, 0);
    check_eq("rst_prev_count", bus.prev_count, 0);
    check_eq("rst_scan_valid", bus.scan_valid, 0);
    check_eq("rst_scan_busy", bus.scan_busy, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    reset_N = 1'b1;

    // Three records, swap, random reads.
    wr_one(3, mk(3, 0), 0);
    wr_one(7, mk(7, 0), 0);
    wr_one(200, mk(200, 0), 0);
    check_eq("cur_count_3", bus.cur_count, 3);
    pulse_fd();
    check_eq("swap_prev_count", bus.prev_count, 3);
    check_eq("swap_cur_count", bus.cur_count, 0);
    do_read(7);
    check_eq("rd7_valid", bus.rd_valid, 1);
    check_eq("rd7_miss", bus.rd_miss, 0);
    check_eq("rd7_data", bus.rd_data, mk(7, 0));
    @(negedge clk);
    check_eq("rd_valid_pulse", bus.rd_valid, 0);
    do_read(4);
    check_eq("rd4_miss", bus.rd_miss, 1);
    check_eq("rd4_valid", bus.rd_valid, 0);
    check_eq("rd4_data", bus.rd_data, 0);

    // Full-rate scan, then a back-pressured scan.
    do_scan(0, 0);
    check_abc_beats();
    do_scan(1, 0);
    check_abc_beats();

    // Deferred swap with writes to 5 and 6 during the scan.
    do_scan(0, 1);
    check_abc_beats();
    check_eq("defer_prev_before", bus.prev_count, 3);
    check_eq("defer_cur_before", bus.cur_count, 2);
    @(negedge clk);
    check_eq("defer_prev_after", bus.prev_count, 2);
    check_eq("defer_cur_after", bus.cur_count, 0);
    repeat (3) @(negedge clk);
    check_eq("merged_swap_prev", bus.prev_count, 2);
    do_read(5);
    check_eq("rd5_data", bus.rd_data, mk(5, 3));
    do_read(6);
    check_eq("rd6_valid", bus.rd_valid, 1);

    // Overwrite and write coinciding with frame_done.
    wr_one(9, mk(9, 1), 0);
    wr_one(9, mk(9, 2), 0);
    check_eq("overwrite_count", bus.cur_count, 1);
    wr_one(10, mk(10, 1), 1);
    check_eq("wr_fd_prev_count", bus.prev_count, 2);
    check_eq("wr_fd_cur_count", bus.cur_count, 0);
    do_read(9);
    check_eq("rd9_data", bus.rd_data, mk(9, 2));
    do_read(10);
    check_eq("rd10_valid", bus.rd_valid, 1);
    check_eq("rd10_data", bus.rd_data, mk(10, 1));

    // Everything is dropped while EN is low.
    @(negedge clk);
    bus.EN = 1'b0; bus.wr = 1'b1; bus.addr = 11; bus.frame_done = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 9;
    @(negedge clk);
    @(negedge clk);
    bus.wr = 1'b0; bus.frame_done = 1'b0; bus.rd_req = 1'b0;
    check_eq("en0_cur_count", bus.cur_count, 0);
    check_eq("en0_prev_count", bus.prev_count, 2);
    check_eq("en0_rd_valid", bus.rd_valid, 0);
    bus.EN = 1'b1;

    // Empty previous bank: scan_start is a no-op.
    pulse_fd();
    check_eq("empty_prev_count", bus.prev_count, 0);
    @(negedge clk);
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("empty_scan_busy", bus.scan_busy, 0);
      check_eq("empty_scan_valid", bus.scan_valid, 0);
      @(negedge clk);
    end

    // Reset while a beat is presented.
    wr_one(1, mk(1, 4), 0);
    pulse_fd();
    wr_one(2, mk(2, 4), 0);
    check_eq("pre_rst_cur", bus.cur_count, 1);
    check_eq("pre_rst_prev", bus.prev_count, 1);
    bus.scan_ready = 1'b0;
    @(negedge clk);
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    for (int i = 0; i < 20 && !bus.scan_valid; i++) @(negedge clk);
    check_eq("pre_rst_scan_valid", bus.scan_valid, 1);
    check_eq("pre_rst_scan_data", bus.scan_data, mk(1, 4));
    reset_N = 1'b0;
    #1;
    check_eq("mid_rst_scan_valid", bus.scan_valid, 0);
    check_eq("mid_rst_scan_busy", bus.scan_busy, 0);
    check_eq("mid_rst_cur", bus.cur_count, 0);
    check_eq("mid_rst_prev", bus.prev_count, 0);
    repeat (2) @(negedge clk);
    reset_N = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oflow_registration_bank.md
Name: oflow_registration_bank

Overview:
- Parametrised successor to the single-bank registration store inside the processing element.
- Holds two frames of object-registration records (current and previous) in ping-pong banks with per-entry valid bits and occupancy counters.
- Exposes a random-access read port and a handshaked scan engine that streams every valid previous-frame record to downstream matching/feature-extraction logic.
- Sits between the detection input stream and the PE compare pipeline.

Parameters:
- DATA_W, 112, record width in bits
- DEPTH, 256, entries per bank
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  in  1  system clock
- reset_N  in  1  asynchronous active-low reset
- EN  in  1  global enable; when low, all state freezes
- wr  in  1  write strobe into current bank
- addr  in  ADDR_W  write address
- data_in  in  DATA_W  write record
- frame_done  in  1  pulse: end of frame, request bank swap
- rd_req  in  1  random read of previous bank
- rd_addr  in  ADDR_W  random read address
- rd_data  out  DATA_W  random read data
- rd_valid  out  1  rd_data valid, and entry was valid
- rd_miss  out  1  read completed but entry invalid
- scan_start  in  1  pulse: begin scan of previous bank
- scan_data  out  DATA_W  streamed record
- scan_addr  out  ADDR_W  index of streamed record
- scan_valid  out  1  stream valid
- scan_ready  in  1  downstream accept
- scan_last  out  1  qualifies final record of scan
- scan_busy  out  1  scan FSM not IDLE
- cur_count  out  ADDR_W+1  valid entries in current bank
- prev_count  out  ADDR_W+1  valid entries in previous bank

Behaviour:
- Reset: all outputs 0, all valid bits 0, cur_bank=0, swap_pending=0, FSM IDLE. Record storage is not reset.
- EN=0: no writes, swaps, reads, or FSM advance. Outputs hold. Inputs presented while EN=0 are dropped; frame_done/scan_start pulses are lost.
- Write (wr & EN):
  - Stores data_in at addr in the current bank and sets its valid bit.
  - cur_count increments only if the entry was previously invalid; an overwrite leaves the count unchanged.
  - addr >= DEPTH is ignored.
- Swap: frame_done & EN while scan_busy=0 swaps at the clock edge:
  - cur_bank toggles.
  - The new current bank's valid bits clear in the same edge; cur_count becomes 0.
  - prev_count takes the old cur_count.
- wr and frame_done in the same cycle: the write lands in the outgoing bank and is counted in the new prev_count.
- Swap during scan:
  - frame_done while scan_busy sets swap_pending.
  - The swap executes on the cycle the FSM returns to IDLE.
  - Writes continue into the current bank meanwhile.
  - Extra frame_done pulses while pending are merged (one swap).
- Random read: rd_req & EN registers the previous-bank entry; 1-cycle latency.
  - Next cycle, exactly one of rd_valid (entry valid) or rd_miss (entry invalid) is high for one cycle.
  - rd_data = stored record on a hit, 0 on a miss.
- Scan FSM, states IDLE, SEEK, FETCH, PRESENT:
  - IDLE: scan_start & EN -> SEEK with idx=0 and remaining=prev_count. If prev_count=0, stay IDLE; no scan_valid.
  - SEEK: examine one index per cycle. On a valid entry -> FETCH. Otherwise idx+1. If idx reaches DEPTH-1 and that entry is invalid -> IDLE (defensive; unreachable while remaining>0).
  - FETCH: register record and idx -> PRESENT.
  - PRESENT: scan_valid=1; scan_data and scan_addr are stable until handshake.
    - scan_last=1 when remaining=1.
    - On scan_valid & scan_ready: remaining-1. If the accepted beat was last -> IDLE, else idx+1 -> SEEK.
- scan_start while busy is ignored.
- The previous bank is read-only during a scan (guaranteed by deferred swap). Random reads may run concurrently with a scan.
- Reset mid-scan: immediate return to IDLE, scan_valid=0, pending swap discarded.

Decomposition:
- Package oflow_pkg holds:
  - OFLOW_DATA_W = 112 and OFLOW_DEPTH = 256 defaults
  - typedef scan_state_t enum {IDLE, SEEK, FETCH, PRESENT}
  - typedef oflow_rec_t logic [OFLOW_DATA_W-1:0]
- Sub-module oflow_reg_bank, instantiated twice:
  - one bank of DEPTH x DATA_W storage, valid vector, occupancy counter
  - write port, two combinational read ports, single-cycle clear input
- Top level owns the bank select, swap/pending logic, random-read register, and scan FSM.

Test Plan:
- Reset, write addr 3, 7, 200 with distinct data, frame_done -> prev_count=3, cur_count=0; rd_addr 7 -> rd_valid next cycle with matching data; rd_addr 4 -> rd_miss, rd_data=0.
- Same 3 entries, scan_start, scan_ready=1 -> three beats, scan_addr 3, 7, 200 in order; scan_last only on addr 200; scan_busy falls after the last beat.
- Scan with scan_ready toggling 0/1 every 2 cycles -> scan_data/scan_addr stable while scan_valid & !scan_ready; no beat lost or duplicated.
- frame_done during scan, with writes to addr 5 and 6 meanwhile -> swap occurs the cycle after the last beat; new prev_count=2; scanned data is unchanged by the swap.
- Overwrite addr 9 twice, plus wr & frame_done in the same cycle at addr 10 -> prev_count=2; addr 9 holds the second value; addr 10 is present in the previous bank.
- scan_start with prev_count=0 -> no scan_valid and scan_busy stays 0. Then reset_N low mid-PRESENT -> scan_valid=0 asynchronously and all counts 0.
